// File: rtl/aud_pkg.sv
// Shared types and constants for the stereo DAC serializer.
package aud_pkg;

  // Serializer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } aud_state_e;

  // Output framing formats selected by i_mode.
  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  // Widest sample the serializer is meant to handle.
  localparam int AUD_MAX_W = 32;

  // Stereo pair at the widest supported width.
  // The top module declares its own DATA_W-sized pair with the same field order.
  typedef struct packed {
    logic [AUD_MAX_W-1:0] l;
    logic [AUD_MAX_W-1:0] r;
  } aud_pair_max_t;

endpackage

// File: rtl/aud_pair_fifo.sv
// Synchronous FIFO for stereo sample pairs.
// The read word is shown before the pop (first-word fall-through).
// The caller must not push when full or pop when empty.
module aud_pair_fifo
  import aud_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + LVL_W'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - LVL_W'(1);
    end
  end

  // Pointer and count registers. A reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array. It is not reset because the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) begin
      mem[wrPtr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem[rdPtr_q];
  assign level_o = count_q;
  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/aud_player_stereo.sv
// Stereo DAC serializer.
// Buffers L/R pairs and shifts them out MSB-first on each codec frame, in I2S or left-justified format.
module aud_player_stereo
  import aud_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data_l,
  input  logic [DATA_W-1:0] i_data_r,
  output logic              o_aud_dacdat,
  output logic              o_underrun,
  output logic [LVL_W-1:0]  o_level
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Pair layout used by the FIFO: left sample in the upper half.
  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  aud_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic              dac_q, dac_d;
  logic              under_q, under_d;
  logic              mode_q, mode_d;
  logic              lrck_q;

  logic              ls, rs;
  logic              pushEn, popEn;
  logic              fifoFull, fifoEmpty;
  logic [2*DATA_W-1:0] fifoRdata;
  pair_t             popPair;
  logic [DATA_W-1:0] loadWord;
  logic              loadEdge, loadLj;

  assign ls     = lrck_q & ~i_daclrck;
  assign rs     = ~lrck_q & i_daclrck;
  assign pushEn = i_valid & ~fifoFull;
  assign popEn  = ls & i_en & ~fifoEmpty;

  aud_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * DATA_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (i_bclk),
    .rst_i   (i_rst),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .wdata_i ({i_data_l, i_data_r}),
    .rdata_o (fifoRdata),
    .level_o (o_level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign popPair = pair_t'(fifoRdata);

  // Next-state logic: frame edges reload the shifter, otherwise step through DELAY/SHIFT/PAD.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    right_d  = right_q;
    mode_d   = mode_q;
    dac_d    = 1'b0;
    under_d  = 1'b0;
    loadWord = '0;
    loadEdge = ls | (rs & (state_q != IDLE));
    loadLj   = ls ? i_mode : mode_q;

    if (ls) begin
      mode_d  = i_mode;
      under_d = i_en & fifoEmpty;
      if (popEn) begin
        loadWord = popPair.l;
        right_d  = popPair.r;
      end else begin
        right_d  = '0;
      end
    end else if (rs) begin
      loadWord = right_q;
    end

    if (loadEdge) begin
      if (loadLj == MODE_LJ) begin
        dac_d   = loadWord[DATA_W-1];
        shift_d = {loadWord[DATA_W-2:0], 1'b0};
        cnt_d   = CNT_W'(1);
        state_d = SHIFT;
      end else begin
        shift_d = loadWord;
        cnt_d   = '0;
        state_d = DELAY;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        DELAY: begin
          dac_d   = shift_q[DATA_W-1];
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            state_d = PAD;
          end else begin
            dac_d   = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        PAD: begin
          state_d = PAD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers.
  // lrck_q tracks the frame clock even in reset, so the level present at release never counts as an edge.
  always_ff @(posedge i_bclk) begin
    lrck_q <= i_daclrck;
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      right_q <= '0;
      dac_q   <= 1'b0;
      under_q <= 1'b0;
      mode_q  <= MODE_I2S;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      dac_q   <= dac_d;
      under_q <= under_d;
      mode_q  <= mode_d;
    end
  end

  assign o_ready      = ~fifoFull;
  assign o_aud_dacdat = dac_q;
  assign o_underrun   = under_q;

endmodule

// File: tb/tb_aud_player_stereo.sv
// Directed self-checking bench for aud_player_stereo with DATA_W=16 and FIFO_DEPTH=4.
module tb_aud_player_stereo;

  logic        clk;
  logic        rst;
  logic        lrck;
  logic        en;
  logic        mode;
  logic        valid;
  logic        ready;
  logic [15:0] dataL;
  logic [15:0] dataR;
  logic        dac;
  logic        underrun;
  logic [2:0]  level;

  int testsRun;
  int testsFailed;

  aud_player_stereo #(
    .DATA_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .i_bclk       (clk),
    .i_rst        (rst),
    .i_daclrck    (lrck),
    .i_en         (en),
    .i_mode       (mode),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_data_l     (dataL),
    .i_data_r     (dataR),
    .o_aud_dacdat (dac),
    .o_underrun   (underrun),
    .o_level      (level)
  );

  // Free-running bit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle. Inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair on the input for exactly one clock edge.
  task automatic pushPair(input logic [15:0] l, input logic [15:0] r);
    dataL = l;
    dataR = r;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    lrck  = 1'b1;
    en    = 1'b0;
    mode  = 1'b1;
    valid = 1'b0;
    dataL = '0;
    dataR = '0;
    repeat (3) tick();
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dac: got %b expected 0", dac); end
    testsRun++;
    if (underrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    testsRun++;
    if (level !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    testsRun++;
    if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lj_frame();
    logic [15:0] cap;
    cap  = '0;
    mode = 1'b1;
    en   = 1'b1;
    pushPair(16'hBA0E, 16'h5E3A);
    testsRun++;
    if (level !== 3'd1) begin testsFailed++; $display("[TB] FAIL lj_level_push: got %0d expected 1", level); end
    lrck = 1'b0;
    tick();
    cap[15] = dac;
    for (int k = 1; k < 16; k++) begin
      tick();
      cap[15-k] = dac;
    end
    testsRun++;
    if (cap !== 16'hBA0E) begin testsFailed++; $display("[TB] FAIL lj_left_word: got %h expected ba0e", cap); end
    tick();
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL lj_left_pad: got %b expected 0", dac); end
    testsRun++;
    if (level !== 3'd0) begin testsFailed++; $display("[TB] FAIL lj_level_pop: got %0d expected 0", level); end
    repeat (3) tick();
    lrck = 1'b1;
    tick();
    cap[15] = dac;
    for (int k = 1; k < 16; k++) begin
      tick();
      cap[15-k] = dac;
    end
    testsRun++;
    if (cap !== 16'h5E3A) begin testsFailed++; $display("[TB] FAIL lj_right_word: got %h expected 5e3a", cap); end
    repeat (4) tick();
  endtask

  task automatic test_i2s_frame();
    logic [15:0] cap;
    cap  = '0;
    mode = 1'b0;
    pushPair(16'hEA19, 16'hF815);
    lrck = 1'b0;
    tick();
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL i2s_left_delay: got %b expected 0", dac); end
    mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      cap[15-k] = dac;
    end
    testsRun++;
    if (cap !== 16'hEA19) begin testsFailed++; $display("[TB] FAIL i2s_left_word: got %h expected ea19", cap); end
    repeat (3) tick();
    lrck = 1'b1;
    tick();
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL i2s_right_delay: got %b expected 0", dac); end
    for (int k = 0; k < 16; k++) begin
      tick();
      cap[15-k] = dac;
    end
    testsRun++;
    if (cap !== 16'hF815) begin testsFailed++; $display("[TB] FAIL i2s_right_word: got %h expected f815", cap); end
    repeat (3) tick();
  endtask

  task automatic test_underrun();
    logic anyDac;
    logic anyUnder;
    anyDac   = 1'b0;
    anyUnder = 1'b0;
    mode     = 1'b1;
    en       = 1'b1;
    testsRun++;
    if (underrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL underrun_idle: got %b expected 0", underrun); end
    lrck = 1'b0;
    tick();
    anyDac = anyDac | dac;
    testsRun++;
    if (underrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL underrun_pulse: got %b expected 1", underrun); end
    for (int k = 0; k < 18; k++) begin
      tick();
      anyDac   = anyDac | dac;
      anyUnder = anyUnder | underrun;
    end
    testsRun++;
    if (anyUnder !== 1'b0) begin testsFailed++; $display("[TB] FAIL underrun_width: got %b expected 0", anyUnder); end
    testsRun++;
    if (anyDac !== 1'b0) begin testsFailed++; $display("[TB] FAIL underrun_silent: got %b expected 0", anyDac); end
    testsRun++;
    if (level !== 3'd0) begin testsFailed++; $display("[TB] FAIL underrun_level: got %0d expected 0", level); end
    lrck = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_disable();
    logic        anyDac;
    logic        anyUnder;
    logic [15:0] cap;
    anyDac   = 1'b0;
    anyUnder = 1'b0;
    cap      = '0;
    pushPair(16'hFFFF, 16'hFFFF);
    en   = 1'b0;
    lrck = 1'b0;
    tick();
    anyDac   = anyDac | dac;
    anyUnder = anyUnder | underrun;
    en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      anyDac   = anyDac | dac;
      anyUnder = anyUnder | underrun;
    end
    testsRun++;
    if (level !== 3'd1) begin testsFailed++; $display("[TB] FAIL disable_level: got %0d expected 1", level); end
    lrck = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      anyDac   = anyDac | dac;
      anyUnder = anyUnder | underrun;
    end
    testsRun++;
    if (anyDac !== 1'b0) begin testsFailed++; $display("[TB] FAIL disable_silent: got %b expected 0", anyDac); end
    testsRun++;
    if (anyUnder !== 1'b0) begin testsFailed++; $display("[TB] FAIL disable_underrun: got %b expected 0", anyUnder); end
    lrck = 1'b0;
    tick();
    cap[15] = dac;
    for (int k = 1; k < 16; k++) begin
      tick();
      cap[15-k] = dac;
    end
    testsRun++;
    if (cap !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL disable_resume_word: got %h expected ffff", cap); end
    testsRun++;
    if (level !== 3'd0) begin testsFailed++; $display("[TB] FAIL disable_resume_level: got %0d expected 0", level); end
    repeat (3) tick();
    lrck = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_fifo_full();
    logic [15:0] cap;
    cap = '0;
    pushPair(16'h1234, 16'h8001);
    pushPair(16'hC3A5, 16'h9F00);
    pushPair(16'hA5C3, 16'hF00F);
    testsRun++;
    if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_ready_at3: got %b expected 1", ready); end
    pushPair(16'hFFFF, 16'hFFFF);
    testsRun++;
    if (ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_ready_at4: got %b expected 0", ready); end
    testsRun++;
    if (level !== 3'd4) begin testsFailed++; $display("[TB] FAIL full_level_at4: got %0d expected 4", level); end
    dataL = 16'h0F0F;
    dataR = 16'hF0F0;
    valid = 1'b1;
    repeat (3) tick();
    testsRun++;
    if (level !== 3'd4) begin testsFailed++; $display("[TB] FAIL full_level_held: got %0d expected 4", level); end
    lrck = 1'b0;
    tick();
    cap[15] = dac;
    testsRun++;
    if (level !== 3'd3) begin testsFailed++; $display("[TB] FAIL full_level_pop: got %0d expected 3", level); end
    testsRun++;
    if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_ready_pop: got %b expected 1", ready); end
    tick();
    valid = 1'b0;
    cap[14] = dac;
    testsRun++;
    if (level !== 3'd4) begin testsFailed++; $display("[TB] FAIL full_level_refill: got %0d expected 4", level); end
    for (int k = 2; k < 16; k++) begin
      tick();
      cap[15-k] = dac;
    end
    testsRun++;
    if (cap !== 16'h1234) begin testsFailed++; $display("[TB] FAIL full_left_word: got %h expected 1234", cap); end
    repeat (4) tick();
    lrck = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_short_slot();
    logic [15:0] cap;
    logic [15:0] expWord;
    logic        anyUnder;
    cap      = '0;
    anyUnder = 1'b0;
    mode     = 1'b1;
    lrck     = 1'b0;
    tick();
    cap[15] = dac;
    anyUnder = anyUnder | underrun;
    for (int k = 1; k < 9; k++) begin
      tick();
      cap[15-k] = dac;
      anyUnder  = anyUnder | underrun;
    end
    tick();
    lrck = 1'b1;
    tick();
    expWord = 16'hC3A5;
    testsRun++;
    if (cap[15:7] !== expWord[15:7]) begin testsFailed++; $display("[TB] FAIL short_lj_bits: got %h expected %h", cap[15:7], expWord[15:7]); end
    testsRun++;
    if (dac !== 1'b1) begin testsFailed++; $display("[TB] FAIL short_lj_restart: got %b expected 1", dac); end
    for (int k = 0; k < 9; k++) begin
      tick();
      anyUnder = anyUnder | underrun;
    end
    mode = 1'b0;
    lrck = 1'b0;
    tick();
    anyUnder = anyUnder | underrun;
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL short_i2s_delay: got %b expected 0", dac); end
    cap = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cap[15-k] = dac;
      anyUnder  = anyUnder | underrun;
    end
    tick();
    lrck = 1'b1;
    tick();
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL short_i2s_rdelay: got %b expected 0", dac); end
    tick();
    expWord = 16'hA5C3;
    testsRun++;
    if (cap[15:8] !== expWord[15:8]) begin testsFailed++; $display("[TB] FAIL short_i2s_bits: got %h expected %h", cap[15:8], expWord[15:8]); end
    testsRun++;
    if (dac !== 1'b1) begin testsFailed++; $display("[TB] FAIL short_i2s_restart: got %b expected 1", dac); end
    testsRun++;
    if (anyUnder !== 1'b0) begin testsFailed++; $display("[TB] FAIL short_underrun: got %b expected 0", anyUnder); end
    testsRun++;
    if (level !== 3'd2) begin testsFailed++; $display("[TB] FAIL short_level: got %0d expected 2", level); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    logic anyDac;
    logic anyUnder;
    anyDac   = 1'b0;
    anyUnder = 1'b0;
    mode     = 1'b1;
    repeat (3) tick();
    lrck = 1'b0;
    tick();
    repeat (3) tick();
    testsRun++;
    if (dac !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_running: got %b expected 1", dac); end
    rst = 1'b1;
    tick();
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_dac: got %b expected 0", dac); end
    testsRun++;
    if (level !== 3'd0) begin testsFailed++; $display("[TB] FAIL rstmid_level: got %0d expected 0", level); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      anyDac   = anyDac | dac;
      anyUnder = anyUnder | underrun;
    end
    testsRun++;
    if (anyDac !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_no_frame: got %b expected 0", anyDac); end
    testsRun++;
    if (anyUnder !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_underrun: got %b expected 0", anyUnder); end
    pushPair(16'h8000, 16'h0001);
    testsRun++;
    if (level !== 3'd1) begin testsFailed++; $display("[TB] FAIL rstmid_push: got %0d expected 1", level); end
    anyDac = 1'b0;
    lrck   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      anyDac = anyDac | dac;
    end
    testsRun++;
    if (anyDac !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_rs_ignored: got %b expected 0", anyDac); end
    lrck = 1'b0;
    tick();
    testsRun++;
    if (dac !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_new_msb: got %b expected 1", dac); end
    tick();
    testsRun++;
    if (dac !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_new_bit14: got %b expected 0", dac); end
    testsRun++;
    if (level !== 3'd0) begin testsFailed++; $display("[TB] FAIL rstmid_new_level: got %0d expected 0", level); end
    repeat (4) tick();
  endtask

  // Run the scenarios in order, then print the summary.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    lrck  = 1'b1;
    en    = 1'b0;
    mode  = 1'b0;
    valid = 1'b0;
    dataL = '0;
    dataR = '0;
    test_reset();
    test_lj_frame();
    test_i2s_frame();
    test_underrun();
    test_disable();
    test_fifo_full();
    test_short_slot();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
